// File: rtl/collider_pkg.sv
// collider_pkg: tile codes, ray directions and FSM states
// shared by tile_collider and tile_is_solid.
package collider_pkg;

   localparam int TILE_EMPTY    = 0;
   localparam int TILE_SOLID    = 1;
   localparam int TILE_PLATFORM = 2;

   typedef enum logic [1:0] {
      LEFT,
      RIGHT,
      UP,
      DOWN
   } ray_dir_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_READ,
      S_CHECK,
      S_DONE
   } state_t;

endpackage

// File: rtl/tile_is_solid.sv
// tile_is_solid: per-visit collision decode of a tile code.
// COLLIDER_ONEWAY_EN makes platforms solid for the down ray only.
module tile_is_solid
   import collider_pkg::*;
#(
   parameter int CODE_W = 4
) (
   input  logic [CODE_W-1:0] code_i,
   input  ray_dir_t          dir_i,
   input  logic              in_map_i,
   output logic              solid_o
);

   logic is_solid;
   logic is_plat;

   assign is_solid = (code_i == CODE_W'(TILE_SOLID));
   assign is_plat  = (code_i == CODE_W'(TILE_PLATFORM));

`ifdef COLLIDER_ONEWAY_EN
   assign solid_o = !in_map_i || is_solid ||
                    (is_plat && (dir_i == DOWN));
`else
   logic unused_dir;
   assign unused_dir = ^dir_i;
   assign solid_o = !in_map_i || is_solid || is_plat;
`endif

endmodule

// File: rtl/tile_collider.sv
// tile_collider: ray-casts the tile map around each player and
// commits X/Y limits atomically. Optional: COLLIDER_ONEWAY_EN.
module tile_collider
   import collider_pkg::*;
#(
   parameter int N_PLAYERS  = 2,
   parameter int COORD_W    = 10,
   parameter int TILE_LOG2  = 4,
   parameter int MAP_COLS   = 40,
   parameter int MAP_ROWS   = 30,
   parameter int PW         = 32,
   parameter int PH         = 48,
   parameter int SCAN_TILES = 4,
   parameter int CODE_W     = 4,
   parameter int X_MIN_DEF  = 0,
   parameter int X_MAX_DEF  = 608,
   parameter int Y_MIN_DEF  = 0,
   parameter int Y_MAX_DEF  = 432
) (
   input  logic                         Clk,
   input  logic                         Reset_n,
   input  logic                         start,
   input  logic [N_PLAYERS*COORD_W-1:0] player_X_Pos,
   input  logic [N_PLAYERS*COORD_W-1:0] player_Y_Pos,
   output logic [$clog2(MAP_COLS*MAP_ROWS)-1:0] map_addr,
   input  logic [CODE_W-1:0]            map_data,
   output logic                         busy,
   output logic                         done,
   output logic [N_PLAYERS*COORD_W-1:0] player_X_Min,
   output logic [N_PLAYERS*COORD_W-1:0] player_X_Max,
   output logic [N_PLAYERS*COORD_W-1:0] player_Y_Min,
   output logic [N_PLAYERS*COORD_W-1:0] player_Y_Max
);

   localparam int AW  = $clog2(MAP_COLS*MAP_ROWS);
   localparam int SW  = COORD_W + 2;
   localparam int TW  = COORD_W - TILE_LOG2 + 2;
   localparam int PIW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam int SCW = (SCAN_TILES > 1) ? $clog2(SCAN_TILES) : 1;

   localparam logic signed [TW-1:0] T_ONE  = TW'(1);
   localparam logic signed [TW-1:0] T_ZERO = TW'(0);
   localparam logic signed [TW-1:0] COLS_T = TW'(MAP_COLS);
   localparam logic signed [TW-1:0] ROWS_T = TW'(MAP_ROWS);
   localparam logic [TW-1:0]        U_ONE  = TW'(1);

   localparam logic [SW-1:0]        PW_M1 = SW'(PW - 1);
   localparam logic [SW-1:0]        PH_M1 = SW'(PH - 1);
   localparam logic signed [SW-1:0] PW_S  = SW'(PW);
   localparam logic signed [SW-1:0] PH_S  = SW'(PH);
   localparam logic signed [SW-1:0] S_ONE = SW'(1);

   localparam logic [AW-1:0]      COLS_A  = AW'(MAP_COLS);
   localparam logic [SCW-1:0]     SC_LAST = SCW'(SCAN_TILES - 1);
   localparam logic [PIW-1:0]     P_LAST  = PIW'(N_PLAYERS - 1);
   localparam logic [COORD_W-1:0] XMIN_V  = COORD_W'(X_MIN_DEF);
   localparam logic [COORD_W-1:0] XMAX_V  = COORD_W'(X_MAX_DEF);
   localparam logic [COORD_W-1:0] YMIN_V  = COORD_W'(Y_MIN_DEF);
   localparam logic [COORD_W-1:0] YMAX_V  = COORD_W'(Y_MAX_DEF);

   typedef struct packed {
      logic signed [TW-1:0] c0;
      logic signed [TW-1:0] c1;
      logic signed [TW-1:0] r0;
      logic signed [TW-1:0] r1;
   } box_t;

   typedef struct packed {
      logic signed [TW-1:0] col;
      logic signed [TW-1:0] row;
   } tile_t;

   function automatic box_t box_of(
      input logic [COORD_W-1:0] x,
      input logic [COORD_W-1:0] y
   );
      box_t          b;
      logic [SW-1:0] xe;
      logic [SW-1:0] ye;
      xe   = SW'(x);
      ye   = SW'(y);
      b.c0 = TW'(xe >> TILE_LOG2);
      b.c1 = TW'((xe + PW_M1) >> TILE_LOG2);
      b.r0 = TW'(ye >> TILE_LOG2);
      b.r1 = TW'((ye + PH_M1) >> TILE_LOG2);
      return b;
   endfunction

   function automatic tile_t tile_of(
      input box_t           b,
      input ray_dir_t       d,
      input logic [SCW-1:0] s,
      input logic [TW-1:0]  j
   );
      tile_t                t;
      logic signed [TW-1:0] ss;
      logic signed [TW-1:0] jj;
      ss = $signed(TW'(s));
      jj = $signed(j);
      t  = '0;
      unique case (d)
         LEFT: begin
            t.col = b.c0 - T_ONE - ss;
            t.row = b.r0 + jj;
         end
         RIGHT: begin
            t.col = b.c1 + T_ONE + ss;
            t.row = b.r0 + jj;
         end
         UP: begin
            t.col = b.c0 + jj;
            t.row = b.r0 - T_ONE - ss;
         end
         DOWN: begin
            t.col = b.c0 + jj;
            t.row = b.r1 + T_ONE + ss;
         end
      endcase
      return t;
   endfunction

   state_t               state_q;
   logic [COORD_W-1:0]   xq [N_PLAYERS];
   logic [COORD_W-1:0]   yq [N_PLAYERS];
   logic [PIW-1:0]       p_q, p_d;
   ray_dir_t             d_q, d_d;
   logic [SCW-1:0]       s_q, s_d;
   logic [TW-1:0]        j_q, j_d;
   logic signed [TW-1:0] col_q, row_q;
   logic                 inmap_q;

   logic [COORD_W-1:0]   xmin_s [N_PLAYERS];
   logic [COORD_W-1:0]   xmax_s [N_PLAYERS];
   logic [COORD_W-1:0]   ymin_s [N_PLAYERS];
   logic [COORD_W-1:0]   ymax_s [N_PLAYERS];

   box_t                 bq, bn;
   tile_t                nxt;
   logic                 nxt_in;
   logic [AW-1:0]        addr_d;
   logic [TW-1:0]        span;
   logic                 solid, ray_end, last_ray;
   logic signed [SW-1:0] hv, ce, re;
   logic [COORD_W-1:0]   res;
   logic                 unused_hv;

   tile_is_solid #(
      .CODE_W(CODE_W)
   ) u_solid (
      .code_i  (map_data),
      .dir_i   (d_q),
      .in_map_i(inmap_q),
      .solid_o (solid)
   );

   // Cursor advance; the next tile address is ready for READ.
   always_comb begin
      bq = box_of(xq[p_q], yq[p_q]);
      if (d_q == LEFT || d_q == RIGHT)
         span = bq.r1 - bq.r0 + T_ONE;
      else
         span = bq.c1 - bq.c0 + T_ONE;
      last_ray = (p_q == P_LAST) && (d_q == DOWN);
      ray_end  = solid ||
                 ((j_q == span - U_ONE) && (s_q == SC_LAST));
      p_d = p_q;
      d_d = d_q;
      s_d = s_q;
      j_d = j_q;
      if (state_q != S_CHECK) begin
         p_d = '0;
         d_d = LEFT;
         s_d = '0;
         j_d = '0;
      end else if (ray_end) begin
         s_d = '0;
         j_d = '0;
         unique case (d_q)
            LEFT:  d_d = RIGHT;
            RIGHT: d_d = UP;
            UP:    d_d = DOWN;
            DOWN: begin
               d_d = LEFT;
               if (!last_ray)
                  p_d = p_q + PIW'(1);
            end
         endcase
      end else if (j_q == span - U_ONE) begin
         s_d = s_q + SCW'(1);
         j_d = '0;
      end else begin
         j_d = j_q + U_ONE;
      end
      bn     = box_of(xq[p_d], yq[p_d]);
      nxt    = tile_of(bn, d_d, s_d, j_d);
      nxt_in = (nxt.col >= T_ZERO) && (nxt.col < COLS_T) &&
               (nxt.row >= T_ZERO) && (nxt.row < ROWS_T);
      if (nxt_in)
         addr_d = AW'($unsigned(nxt.row)) * COLS_A +
                  AW'($unsigned(nxt.col));
      else
         addr_d = '0;
   end

   always_comb begin
      ce = {{(SW-TW){col_q[TW-1]}}, col_q};
      re = {{(SW-TW){row_q[TW-1]}}, row_q};
      hv = '0;
      unique case (d_q)
         LEFT:  hv = (ce + S_ONE) <<< TILE_LOG2;
         RIGHT: hv = (ce <<< TILE_LOG2) - PW_S;
         UP:    hv = (re + S_ONE) <<< TILE_LOG2;
         DOWN:  hv = (re <<< TILE_LOG2) - PH_S;
      endcase
      unused_hv = hv[COORD_W];
      res = '0;
      if (solid) begin
         res = hv[SW-1] ? '0 : hv[COORD_W-1:0];
      end else begin
         unique case (d_q)
            LEFT:  res = XMIN_V;
            RIGHT: res = XMAX_V;
            UP:    res = YMIN_V;
            DOWN:  res = YMAX_V;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         map_addr     <= '0;
         p_q          <= '0;
         d_q          <= LEFT;
         s_q          <= '0;
         j_q          <= '0;
         col_q        <= '0;
         row_q        <= '0;
         inmap_q      <= 1'b0;
         player_X_Min <= {N_PLAYERS{XMIN_V}};
         player_X_Max <= {N_PLAYERS{XMAX_V}};
         player_Y_Min <= {N_PLAYERS{YMIN_V}};
         player_Y_Max <= {N_PLAYERS{YMAX_V}};
         for (int p = 0; p < N_PLAYERS; p++) begin
            xq[p]     <= '0;
            yq[p]     <= '0;
            xmin_s[p] <= XMIN_V;
            xmax_s[p] <= XMAX_V;
            ymin_s[p] <= YMIN_V;
            ymax_s[p] <= YMAX_V;
         end
      end else begin
         done <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int p = 0; p < N_PLAYERS; p++) begin
                     xq[p] <= player_X_Pos[p*COORD_W +: COORD_W];
                     yq[p] <= player_Y_Pos[p*COORD_W +: COORD_W];
                  end
                  state_q <= S_LATCH;
               end
            end
            S_LATCH: begin
               busy     <= 1'b1;
               p_q      <= p_d;
               d_q      <= d_d;
               s_q      <= s_d;
               j_q      <= j_d;
               col_q    <= nxt.col;
               row_q    <= nxt.row;
               inmap_q  <= nxt_in;
               map_addr <= addr_d;
               state_q  <= S_READ;
            end
            S_READ: begin
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               if (ray_end) begin
                  unique case (d_q)
                     LEFT:  xmin_s[p_q] <= res;
                     RIGHT: xmax_s[p_q] <= res;
                     UP:    ymin_s[p_q] <= res;
                     DOWN:  ymax_s[p_q] <= res;
                  endcase
               end
               if (ray_end && last_ray) begin
                  state_q <= S_DONE;
               end else begin
                  p_q      <= p_d;
                  d_q      <= d_d;
                  s_q      <= s_d;
                  j_q      <= j_d;
                  col_q    <= nxt.col;
                  row_q    <= nxt.row;
                  inmap_q  <= nxt_in;
                  map_addr <= addr_d;
                  state_q  <= S_READ;
               end
            end
            S_DONE: begin
               busy <= 1'b0;
               done <= 1'b1;
               for (int p = 0; p < N_PLAYERS; p++) begin
                  player_X_Min[p*COORD_W +: COORD_W] <= xmin_s[p];
                  player_X_Max[p*COORD_W +: COORD_W] <= xmax_s[p];
                  player_Y_Min[p*COORD_W +: COORD_W] <= ymin_s[p];
                  player_Y_Max[p*COORD_W +: COORD_W] <= ymax_s[p];
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
